serial_word_deframer: RTL
=========================

// Module: serial_word_deframer
// PURPOSE
//   Downstream consumer of the single-bit registered stream produced by the
//   d_in/d_out pipeline stage. Hunts for a sync word in the serial stream and
//   locks onto it. Then assembles WIDTH-bit data words, MSB first, and buffers
//   them in a small FIFO. Words are presented with a valid/ready handshake.
//   One clock; reset is synchronous and active-high.
// PARAMETERS
//   WIDTH     8      data/sync word width in bits (>= 2)
//   SYNC      8'hA5  sync pattern, WIDTH bits; the first match locks the block
//   DEPTH     4      output FIFO depth in words (power of 2, >= 2)
// PORTS
//   clk         in   1      single clock; all state updates on posedge
//   rst         in   1      synchronous, active-high reset
//   bit_in      in   1      serial data bit (upstream d_out)
//   bit_en      in   1      bit_in is sampled only on cycles with bit_en=1
//   resync      in   1      1-cycle pulse: drop lock, flush FIFO, return to HUNT
//   word_out    out  WIDTH  head-of-FIFO word; valid only while word_valid=1
//   word_valid  out  1      FIFO not empty
//   word_ready  in   1      consumer accepts word_out when word_valid & word_ready
//   locked      out  1      1 while in LOCKED
//   overflow    out  1      sticky; a completed word was dropped on a full FIFO
// BEHAVIOUR
//   - Reset: state=HUNT, shift reg=0, bit count=0, FIFO empty.
//     Outputs after reset: word_valid=0, locked=0, overflow=0, word_out=0.
//   - Shift: on bit_en=1, sr <= {sr[WIDTH-2:0], bit_in}. The first bit is the MSB.
//   - HUNT: on a bit_en edge where {sr[WIDTH-2:0],bit_in}==SYNC, go to LOCKED
//     and set bit count=0. locked=1 from the next cycle.
//   - LOCKED: each bit_en edge increments the bit count, which wraps at WIDTH-1 -> 0.
//     At the edge that samples bit WIDTH-1, the word {sr[WIDTH-2:0],bit_in} is pushed.
//     word_valid rises the cycle after the last bit is sampled (1-cycle latency).
//   - In LOCKED, a SYNC pattern in the data is ordinary data; there is no realignment.
//   - FIFO: first-word fall-through. Pop occurs on word_valid & word_ready.
//     Word order is preserved.
//   - Push to a full FIFO with no pop on the same edge: the word is dropped,
//     overflow <= 1, and the stored contents are unchanged.
//   - Push and pop on the same edge while full: both take effect, and overflow
//     is not set.
//   - Push and pop on the same edge while empty: the push wins and the word is
//     visible next cycle.
//   - Priority: rst > resync > bit_en. resync causes the following on the next
//     edge: HUNT, bit count=0, sr=0, FIFO flushed, overflow cleared. Any
//     partial word is discarded.
//   - Reset mid-word or mid-handshake: everything is cleared on that edge.
//     A word presented but not accepted is lost.
//   - bit_en=0: sr, bit count and state all hold. The FIFO may still pop.
//   - Bit count width: $clog2(WIDTH). FIFO pointers: $clog2(DEPTH)+1 bits, with
//     full/empty determined by comparing the MSB.
// STRUCTURE
//   - deframer_pkg: typedef enum logic {HUNT, LOCKED} deframer_state_t;
//     localparam DEFAULT_SYNC = 8'hA5.
//   - Sub-module deframer_fifo #(WIDTH, DEPTH): synchronous FWFT FIFO with
//     push, pop, flush, full, empty, dout. The top level holds the shift
//     register, the bit counter, the state machine and the overflow flag.
// TESTING (WIDTH=8, SYNC=8'hA5, DEPTH=4)
//   1. Hold rst=1 for 2 cycles with random bit_in -> word_valid=0, locked=0,
//      overflow=0.
//   2. Stream 8'h3C, then A5, 3C, 81 (MSB first), with bit_en=1 and
//      word_ready=1 -> no lock during the first 3C. locked=1 one cycle after
//      the 8th A5 bit. Words 3C and 81 appear, each with word_valid one cycle
//      after its 8th bit.
//   3. Same stream as test 2 with bit_en pattern 1,0,0,1,... -> identical
//      words, and locked and word_valid timing stretched by the gaps.
//   4. Lock, set word_ready=0, send 11,22,33,44,55 -> word_valid=1 and
//      overflow=1 after 55. Draining yields 11,22,33,44, then word_valid=0.
//   5. FIFO full and word_ready=1 on the edge that completes word 66 ->
//      overflow stays 0. The FIFO then holds 22,33,44,66.
//   6. Assert resync (and separately rst) after 5 bits of a word -> locked=0
//      and word_valid=0 next cycle, overflow=0. A re-sent A5 followed by 5A
//      delivers 5A.

Source files
------------

// File: rtl/serial_word_deframer_pkg.sv
// Shared types and defaults for the serial word deframer.
// The state enum and default sync pattern are used by the top level and the bench.
package deframer_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } deframer_state_t;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/serial_word_deframer_if.sv
// Serial bit input, control pulses and word output handshake of the deframer.
// The master side drives bits and ready; the slave side is the deframer.
interface serial_word_deframer_if #(
  parameter int WIDTH = 8
);

  logic             bit_in;
  logic             bit_en;
  logic             resync;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             locked;
  logic             overflow;

  modport master (
    output bit_in, bit_en, resync, word_ready,
    input  word_out, word_valid, locked, overflow
  );

  modport slave (
    input  bit_in, bit_en, resync, word_ready,
    output word_out, word_valid, locked, overflow
  );

endinterface

// File: rtl/serial_word_deframer_fifo.sv
// First-word-fall-through FIFO for assembled words.
// Latency: a pushed word is visible at dout one cycle later. Backpressure: push on full is ignored unless a pop happens on the same edge.
module deframer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates the wrapped-full case from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_word_deframer.sv
// Hunts for SYNC in a serial stream, then assembles MSB-first words into a FWFT FIFO.
// Latency: lock and word_valid rise one cycle after the last sampled bit. Backpressure: words arriving on a full FIFO are dropped and flagged in sticky overflow.
module serial_word_deframer
  import deframer_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DEFAULT_SYNC),
  parameter int               DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  serial_word_deframer_if.slave dif
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  deframer_state_t  state;
  deframer_state_t  state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] next_sr;
  logic [CW-1:0]    cnt;
  logic             overflow_q;
  logic             sync_hit;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign next_sr  = {sr[WIDTH-2:0], dif.bit_in};
  assign sync_hit = dif.bit_en && (next_sr == SYNC);
  assign push     = (state == LOCKED) && dif.bit_en && (cnt == LAST) && !dif.resync;
  assign pop      = !fifo_empty && dif.word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (dif.resync) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT:    if (sync_hit) state_nxt = LOCKED;
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    dif.locked = (state == LOCKED);
  end

  // The counter stays at zero while hunting, so the lock edge leaves it at zero.
  always_ff @(posedge clk) begin
    if (rst || dif.resync) begin
      sr         <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (dif.bit_en) begin
        sr <= next_sr;
        if (state == LOCKED) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else begin
          cnt <= '0;
        end
      end
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  deframer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (next_sr),
    .pop   (pop),
    .flush (dif.resync),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (dif.word_out)
  );

  assign dif.word_valid = !fifo_empty;
  assign dif.overflow   = overflow_q;

endmodule
